// File: rtl/mem_stage.sv
// Memory-access pipeline stage: accepts execute results, waits on the data SRAM for loads,
// aligns/extends the returned word and hands the result to wb_stage over valid/allowin.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 73,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [38:0]                ms_to_ds_bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t                     state_q, state_d;
    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q, es_bus_d;
    logic                       got_data_q, got_data_d;
    logic [31:0]                rdata_r_q, rdata_r_d;

    logic [31:0] pc, alu_result, raw_word, load_data, rf_wdata;
    logic [2:0]  load_op;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [1:0]  a;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_load, in_is_load, data_ok, ms_ready_go;

    always_comb begin
        pc         = es_bus_q[72:41];
        load_op    = es_bus_q[40:38];
        rf_we      = es_bus_q[37];
        rf_addr    = es_bus_q[36:32];
        alu_result = es_bus_q[31:0];
        a          = alu_result[1:0];
        is_load    = (load_op >= 3'd1) && (load_op <= 3'd5);
        in_is_load = (es_to_ms_bus[40:38] >= 3'd1) && (es_to_ms_bus[40:38] <= 3'd5);
        // A data_ok pulse only counts while a load is actually waiting for it.
        data_ok     = data_sram_data_ok && (state_q == S_WAIT);
        ms_ready_go = !is_load || data_ok || got_data_q;
        ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
    end

    always_comb begin
        raw_word = data_ok ? data_sram_rdata : rdata_r_q;
        case (a)
            2'd0:    byte_sel = raw_word[7:0];
            2'd1:    byte_sel = raw_word[15:8];
            2'd2:    byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase
        half_sel = a[1] ? raw_word[31:16] : raw_word[15:0];
        case (load_op)
            3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    load_data = {24'd0, byte_sel};
            3'd3:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_data = {16'd0, half_sel};
            default: load_data = raw_word;
        endcase
        rf_wdata     = is_load ? load_data : alu_result;
        ms_to_ws_bus = {pc, rf_we, rf_addr, rf_wdata};
        ms_to_ds_bus = {ms_valid_q && rf_we, rf_addr, ms_to_ws_valid, rf_wdata};
    end

    always_comb begin
        ms_valid_d = ms_allowin ? es_to_ms_valid : ms_valid_q;
        es_bus_d   = (ms_allowin && es_to_ms_valid) ? es_to_ms_bus : es_bus_q;
        state_d    = state_q;
        got_data_d = got_data_q;
        rdata_r_d  = rdata_r_q;
        if (ms_allowin) begin
            got_data_d = 1'b0;
            state_d    = (es_to_ms_valid && in_is_load) ? S_WAIT : S_IDLE;
        end else if (data_ok) begin
            // wb_stage is stalled: park the returned word until it drains.
            got_data_d = 1'b1;
            rdata_r_d  = data_sram_rdata;
            state_d    = S_HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ms_valid_q <= 1'b0;
            es_bus_q   <= '0;
            got_data_q <= 1'b0;
            rdata_r_q  <= '0;
        end else begin
            state_q    <= state_d;
            ms_valid_q <= ms_valid_d;
            es_bus_q   <= es_bus_d;
            got_data_q <= got_data_d;
            rdata_r_q  <= rdata_r_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table plus scoreboard of expected ms_to_ws_bus transfers,
// with hand-written back-to-back and reset-during-load sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_valid;
    logic [72:0] es_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ws_bus;
    logic        data_ok;
    logic [31:0] rdata;
    logic [38:0] ds_bus;

    int n_chk  = 0;
    int n_pass = 0;
    logic [69:0] sb[$];
    logic [69:0] mon_exp;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_valid),
        .es_to_ms_bus      (es_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ws_bus),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ms_to_ds_bus      (ds_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] alu;
        logic [31:0] rd;
        int          wait_cyc;
        int          hold_cyc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] w);
        logic [31:0] b, h;
        b = w >> (8 * a);
        h = w >> (16 * a[1]);
        case (op)
            3'd1:    return {{24{b[7]}}, b[7:0]};
            3'd2:    return {24'd0, b[7:0]};
            3'd3:    return {{16{h[15]}}, h[15:0]};
            3'd4:    return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    // Scoreboard: every handshake toward wb_stage must match the oldest expected result.
    always @(negedge clk) begin
        if (reset && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_xfer: got %h want none", ws_bus);
            end else begin
                mon_exp = sb.pop_front();
                chk("sb_xfer", ws_bus, mon_exp);
            end
        end
    end

    task automatic run_vec(input int i);
        vec_t        v;
        logic [31:0] pc;
        logic [4:0]  ra;
        logic        ld;
        v  = vecs[i];
        pc = 32'h0040_0000 + 32'(i * 16);
        ra = 5'(i + 5);
        ld = (v.op >= 3'd1) && (v.op <= 3'd5);
        @(posedge clk); #1;
        es_valid = 1'b1; es_bus = {pc, v.op, 1'b1, ra, v.alu};
        ws_allowin = 1'b1; data_ok = 1'b0;
        chk("accept_allowin", 70'(ms_allowin), 70'(1'b1));
        sb.push_back({pc, 1'b1, ra, v.exp});
        @(posedge clk); #1;
        es_valid = 1'b0; es_bus = {9'($urandom), $urandom, $urandom};
        if (!ld) begin
            @(negedge clk);
            chk("nl_valid", 70'(ms_to_ws_valid), 70'(1'b1));
            chk("nl_fwd_ctl", 70'(ds_bus[38:32]), 70'({1'b1, ra, 1'b1}));
            chk("nl_fwd_data", 70'(ds_bus[31:0]), 70'(v.exp));
        end else begin
            for (int w = 0; w < v.wait_cyc; w++) begin
                @(negedge clk);
                chk("stall_allow_valid", 70'({ms_allowin, ms_to_ws_valid}), 70'(2'b00));
                chk("stall_fwd_we_rdy", 70'({ds_bus[38], ds_bus[32]}), 70'(2'b10));
                @(posedge clk); #1;
            end
            data_ok = 1'b1; rdata = v.rd; ws_allowin = (v.hold_cyc == 0);
            @(negedge clk);
            chk("dok_valid", 70'(ms_to_ws_valid), 70'(1'b1));
            chk("dok_wdata", 70'(ws_bus[31:0]), 70'(v.exp));
            for (int h = 1; h < v.hold_cyc; h++) begin
                @(posedge clk); #1;
                data_ok = 1'b0; rdata = $urandom;
                @(negedge clk);
                chk("hold_valid", 70'({ms_to_ws_valid, ms_allowin}), 70'(2'b10));
                chk("hold_wdata", 70'(ws_bus[31:0]), 70'(v.exp));
            end
            @(posedge clk); #1;
            data_ok = 1'b0; rdata = $urandom; ws_allowin = 1'b1;
        end
    endtask

    initial begin
        logic [2:0]  b_op[4];
        logic [31:0] b_alu[4];
        logic [31:0] b_rd[4];
        logic [4:0]  ra;

        vecs[0]  = '{3'd0, 32'h1234_5678, 32'h0,         0, 0, 32'h1234_5678};
        vecs[1]  = '{3'd1, 32'h0010_0003, 32'h80AA_BBCC, 2, 0, 32'hFFFF_FF80};
        vecs[2]  = '{3'd2, 32'h0010_0003, 32'h80AA_BBCC, 2, 0, 32'h0000_0080};
        vecs[3]  = '{3'd3, 32'h0010_0002, 32'h8001_1234, 1, 0, 32'hFFFF_8001};
        vecs[4]  = '{3'd4, 32'h0010_0000, 32'h8001_1234, 1, 0, 32'h0000_1234};
        vecs[5]  = '{3'd5, 32'h0010_0000, 32'hDEAD_BEEF, 1, 3, 32'hDEAD_BEEF};
        vecs[6]  = '{3'd1, 32'h0010_0001, 32'h80AA_BBCC, 0, 1, 32'hFFFF_FFBB};
        vecs[7]  = '{3'd3, 32'h0010_0000, 32'h1234_7FFF, 0, 0, 32'h0000_7FFF};
        vecs[8]  = '{3'd6, 32'hCAFE_F00D, 32'h0,         0, 0, 32'hCAFE_F00D};
        vecs[9]  = '{3'd2, 32'h0010_0002, 32'h80AA_BBCC, 3, 2, 32'h0000_00AA};
        vecs[10] = '{3'd4, 32'h0010_0003, 32'h8001_1234, 0, 0, 32'h0000_8001};

        reset = 1'b0; es_valid = 1'b0; es_bus = '0; ws_allowin = 1'b1;
        data_ok = 1'b0; rdata = '0;
        #3;
        chk("rst_allow_valid", 70'({ms_allowin, ms_to_ws_valid}), 70'(2'b10));
        chk("rst_ds_bus", 70'(ds_bus), 70'(0));
        chk("rst_ws_bus", ws_bus, 70'(0));
        @(posedge clk); #1; reset = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i);

        // Back-to-back loads, data_ok every cycle: one result per cycle.
        b_op = '{3'd5, 3'd1, 3'd4, 3'd3};
        for (int k = 0; k < 4; k++) begin
            b_alu[k] = $urandom;
            b_rd[k]  = $urandom;
        end
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
            ws_allowin = 1'b1;
            if (k < 4) begin
                ra = 5'(k + 20);
                es_valid = 1'b1;
                es_bus = {32'h0080_0000 + 32'(k * 4), b_op[k], 1'b1, ra, b_alu[k]};
                sb.push_back({32'h0080_0000 + 32'(k * 4), 1'b1, ra,
                              model(b_op[k], b_alu[k][1:0], b_rd[k])});
            end else begin
                es_valid = 1'b0;
            end
            if (k > 0) begin
                data_ok = 1'b1; rdata = b_rd[k-1];
                @(negedge clk);
                chk("b2b_valid_allow", 70'({ms_to_ws_valid, ms_allowin}), 70'(2'b11));
            end
        end
        @(posedge clk); #1; data_ok = 1'b0;

        // Reset while a load waits; a late data_ok afterwards must be ignored.
        @(posedge clk); #1;
        es_valid = 1'b1; es_bus = {32'h0090_0000, 3'd5, 1'b1, 5'd9, 32'h0000_0100};
        @(posedge clk); #1; es_valid = 1'b0;
        @(negedge clk);
        chk("rstw_pre_allow", 70'(ms_allowin), 70'(1'b0));
        #1 reset = 1'b0;
        #1;
        chk("rstw_allow_valid", 70'({ms_allowin, ms_to_ws_valid}), 70'(2'b10));
        chk("rstw_ds_bus", 70'(ds_bus), 70'(0));
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; data_ok = 1'b1; rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("late_dok_allow_valid", 70'({ms_allowin, ms_to_ws_valid}), 70'(2'b10));
        @(posedge clk); #1; data_ok = 1'b0;
        @(negedge clk);
        chk("late_dok_after", 70'({ms_allowin, ms_to_ws_valid}), 70'(2'b10));

        chk("sb_drained", 70'(sb.size()), 70'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
